instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Producer end of the decode interface: fetches 32-bit RISC-V instructions from instruction memory and delivers them, with their PC, to the control unit.
- Presents split opcode/funct3/funct7 fields plus the raw word under a valid/ready handshake.
- Buffers returning instructions in a small in-order FIFO.
- Handles branch/jump redirects by flushing the FIFO and squashing in-flight memory responses.

Parameters:
- FIFO_DEPTH, 4, prefetch buffer entries (power of 2, >=2)
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (>=1)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle (req&gnt = handshake)
- imem_rvalid_i  in  1  response valid, in request order
- imem_rdata_i  in  32  response instruction word
- redirect_i  in  1  branch/jump taken; restart fetch
- redirect_pc_i  in  32  new fetch PC
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  decode accepts head
- instr_o  out  32  head instruction word
- pc_o  out  32  head PC
- opcode_o  out  7  instr_o[6:0]
- funct3_o  out  3  instr_o[14:12]
- funct7_o  out  7  instr_o[31:25]

Behaviour:
- Interface (decided): one clock, clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o/pc_o=0, fetch_pc=RESET_PC, outstanding=0, squash_cnt=0, FIFO empty, FSM=BOOT.
- FSM states:
  - BOOT: one cycle after reset release; no request; goes to RUN.
  - RUN: normal fetch.
  - SQUASH: squash_cnt>0; requests still allowed; goes to RUN when squash_cnt reaches 0.
- Request rule: imem_req_o = (state!=BOOT) & !redirect_i & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding - squash_cnt < FIFO_DEPTH).
  - Guarantees every live response has a FIFO slot; no response is ever back-pressured.
- imem_addr_o = fetch_pc, combinational.
  - Once raised, req and addr are held until gnt unless a redirect occurs.
  - On req&gnt: fetch_pc += 4, modulo 2^32 (wraps 0xFFFF_FFFC -> 0).
- outstanding counter:
  - +1 on req&gnt; -1 on rvalid; both in the same cycle: unchanged.
  - rvalid while outstanding==0 is a protocol error; the response is ignored.
- Response path: each live response pushes {pc, rdata} into the FIFO; pc comes from a per-request PC queue of depth MAX_OUTSTANDING. Responses arriving while squash_cnt>0 are dropped and squash_cnt decrements.
- Decode side:
  - instr_valid_o = FIFO non-empty; head fields are driven from FIFO storage (registered).
  - Pop on instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Empty FIFO: a same-cycle response appears on instr_valid_o next cycle (1-cycle rvalid-to-valid latency).
- Redirect (highest priority):
  - At the edge: fetch_pc <= {redirect_pc_i[31:2], 2'b00}; FIFO flushed; PC queue cleared.
  - squash_cnt <= outstanding, after applying a same-cycle rvalid. The rvalid response is itself dropped.
  - imem_req_o is forced low in the redirect cycle.
  - A pop in the same cycle completes (decode consumed it) and is then flushed.
  - Back-to-back redirects: the last one wins; squash_cnt is recomputed each time.
- Reset asserted mid-operation: immediate return to reset values; in-flight responses after reset release are not expected (memory is reset together with the unit).

Optional Feature:
- IFU_PERF_CNT_EN defined: adds output ports fetch_stall_cnt_o[31:0] and squash_cnt_total_o[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - fetch_stall_cnt_o increments each cycle with instr_valid_o=0 & state==RUN.
  - squash_cnt_total_o increments per dropped response.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- defines.v gains: IFU FSM state encodings (IFU_BOOT, IFU_RUN, IFU_SQUASH), INSTR_NOP 32'h0000_0013 constant, and field bit-range macros for opcode, funct3 and funct7 shared with control_unit.
- One natural sub-module: ifu_fifo (synchronous, parameterised width/depth, push/pop/flush, count output), instantiated twice:
  - 64-bit instruction FIFO
  - 32-bit PC queue (depth MAX_OUTSTANDING)

Test Plan:
- Reset release, gnt=1, rvalid 1 cycle after gnt -> first imem_req_o in cycle 2 with addr 0x0; pc_o sequence 0x0, 0x4, 0x8 on consecutive accepted cycles.
- instr_ready_i=0, memory always grants -> exactly 4 entries buffered, imem_req_o drops; the first pop re-enables requests; no response is lost.
- 2 outstanding requests, redirect_i with redirect_pc_i=0x103 -> next 2 rvalid dropped; next fetch addr 0x100; first delivered pc_o=0x100.
- Redirect in the same cycle as rvalid and pop, with 2 outstanding -> squash_cnt=1, FIFO empty next cycle, imem_req_o=0 in the redirect cycle.
- Response 0x40A28233 -> opcode_o=0x33, funct3_o=0, funct7_o=0x20, instr_o unchanged.
- fetch_pc=0xFFFF_FFFC granted -> next addr 0x0000_0000; reset asserted mid-stream -> outputs at reset values the same cycle (asynchronous).

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// fetch-buffer entry layout and RISC-V field positions used by decode.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IFU_BOOT   = 2'd0,
    IFU_RUN    = 2'd1,
    IFU_SQUASH = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous in-order FIFO with push/pop/flush and an occupancy count.
// Used for the instruction buffer and for the per-request PC queue.
module instr_fetch_unit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_push = push_i & (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the head is masked to zero while empty, so
  // stale contents are never observable.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RISC-V instruction fetch unit: issues word fetches, buffers responses in
// order and squashes in-flight responses on redirect. IFU_PERF_CNT_EN adds
// stall/squash performance counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt_o,
  output logic [31:0] squash_cnt_total_o
`endif
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

  ifu_state_e       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] squash_cnt_q, squash_cnt_d;

  logic             grant, rsp_accept, rsp_live, rsp_drop, pop;
  logic [31:0]      occupancy;
  logic [FIFO_CW-1:0] fifo_count;
  logic [OUT_W-1:0] pcq_count;
  logic [31:0]      pcq_head;
  fetch_entry_t     head;

  // In-flight responses already owed to a flushed stream do not need a slot.
  assign occupancy  = 32'(fifo_count) + 32'(outstanding_q) - 32'(squash_cnt_q);
  assign imem_req_o = (state_q != IFU_BOOT) & ~redirect_i
                    & (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                    & (occupancy < 32'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign grant      = imem_req_o & imem_gnt_i;
  assign rsp_accept = imem_rvalid_i & (outstanding_q != '0);
  assign rsp_live   = rsp_accept & ~redirect_i & (squash_cnt_q == '0) & (pcq_count != '0);
  assign rsp_drop   = rsp_accept & (redirect_i | (squash_cnt_q != '0));
  assign pop        = instr_valid_o & instr_ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OUT_W'(grant) - OUT_W'(rsp_accept);
    squash_cnt_d  = squash_cnt_q;

    if (redirect_i) begin
      fetch_pc_d   = align_word(redirect_pc_i);
      squash_cnt_d = outstanding_q - OUT_W'(rsp_accept);
    end else begin
      if (grant)    fetch_pc_d   = fetch_pc_q + 32'd4;
      if (rsp_drop) squash_cnt_d = squash_cnt_q - OUT_W'(1);
    end

    case (state_q)
      IFU_BOOT: state_d = IFU_RUN;
      default:  state_d = (squash_cnt_d != '0) ? IFU_SQUASH : IFU_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IFU_BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      squash_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      squash_cnt_q  <= squash_cnt_d;
    end
  end

  instr_fetch_unit_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (grant),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_live),
    .flush_i (redirect_i),
    .head_o  (pcq_head),
    .count_o (pcq_count)
  );

  instr_fetch_unit_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (rsp_live),
    .data_i  ({pcq_head, imem_rdata_i}),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;
  assign opcode_o      = head.instr[OPCODE_MSB:OPCODE_LSB];
  assign funct3_o      = head.instr[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_o      = head.instr[FUNCT7_MSB:FUNCT7_LSB];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt_q, squash_total_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q    <= '0;
      squash_total_q <= '0;
    end else begin
      if (!instr_valid_o && state_q == IFU_RUN && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (rsp_drop && squash_total_q != '1)
        squash_total_q <= squash_total_q + 32'd1;
    end
  end

  assign fetch_stall_cnt_o  = stall_cnt_q;
  assign squash_cnt_total_o = squash_total_q;
`else
  // Performance counters excluded from this build.
`endif

endmodule
